// File: rtl/dbg_rf_arbiter_pkg.sv
// Shared types and constants for the register-file debug read arbiter.
package dbg_rf_arbiter_pkg;

  // Register address alias kept for the legacy 32-entry register file.
  typedef logic [4:0] logic5;
  typedef logic5      dbg_addr_t;

  // Two-state read FSM; constants keep the encoding explicit for older tools.
  typedef logic [0:0] dbg_state_t;
  localparam dbg_state_t ST_IDLE = 1'b0;
  localparam dbg_state_t ST_READ = 1'b1;

  // Width of a channel index; never zero so N=1 still gets a real signal.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbg_rf_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or above
// ptr, wrapping modulo N. Generic enough for other shared ports.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int          idx;
  logic [PW-1:0] sel;
  logic        found;

  // Scan N positions starting at ptr; explicit subtract handles non-pow2 N.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = |req;
    found      = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        found           = 1'b1;
        gnt_onehot[sel] = 1'b1;
        gnt_idx         = sel;
      end
    end
  end

endmodule

// File: rtl/dbg_rf_arbiter.sv
// Multi-channel debug read port: round-robin serialises per-channel register
// reads onto the register file's single combinational debug read port.
module dbg_rf_arbiter
  import dbg_rf_arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [N_CH*AW-1:0]   req_addr,
  output logic [N_CH-1:0]      req_ready,
  output logic [N_CH-1:0]      rsp_valid,
  output logic [N_CH*DW-1:0]   rsp_data,
  output logic [AW-1:0]        rf_ra,
  input  logic [DW-1:0]        rf_rd
);

  localparam int PW = ptr_w(N_CH);

  dbg_state_t                 state;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              gnt_q;
  logic [PW-1:0]              gnt_idx;
  logic [PW-1:0]              nxt_ptr;
  logic [N_CH-1:0]            gnt_onehot;
  logic                       any;
  logic [N_CH-1:0][AW-1:0]    addr_v;
  logic [N_CH-1:0][DW-1:0]    data_q;

  assign addr_v   = req_addr;
  assign rsp_data = data_q;

  rr_arbiter #(
    .N  (N_CH),
    .PW (PW)
  ) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // Accept only in IDLE and never while reset is held.
  assign req_ready = (!rst && state == ST_IDLE) ? gnt_onehot : '0;

  // Pointer moves just past the winner; explicit wrap for non-pow2 N_CH.
  assign nxt_ptr = (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // IDLE latches the winner's address; READ captures rf_rd and pulses the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      rf_ra     <= '0;
      rsp_valid <= '0;
      data_q    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            rf_ra  <= addr_v[gnt_idx];
            gnt_q  <= gnt_idx;
            rr_ptr <= nxt_ptr;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          data_q[gnt_q]    <= rf_rd;
          rsp_valid[gnt_q] <= 1'b1;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_rf_arbiter.sv
// Bench for dbg_rf_arbiter with three channels: directed scenarios plus a
// randomized phase, all outputs compared against a transaction-level model.
module tb_dbg_rf_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N*DW-1:0]   rsp_data;
  logic [AW-1:0]     rf_ra;
  logic [DW-1:0]     rf_rd;

  logic [DW-1:0]     regfile [32];

  always #5 clk = ~clk;

  assign rf_rd = regfile[rf_ra];

  dbg_rf_arbiter #(.N_CH(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  bit              armed = 0;
  bit              m_busy;
  int              m_ptr, m_g;
  logic [AW-1:0]   m_ra;
  logic [N-1:0]    m_rv;
  logic [DW-1:0]   m_data [N];
  int              waits [N];
  int              grant_tot [N];
  int              rsp_count [N];
  int              grant_log [$];
  int              grant_cyc [$];
  int              cyc = 0;

  always @(negedge clk) begin
    int g, c;
    logic [N-1:0] er;
    g = -1;
    if (!rst && !m_busy)
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    er = '0;
    if (g >= 0) er = N'(1) << g;
    if (armed) begin
      chk("req_ready", req_ready, er);
      chk("rf_ra", rf_ra, m_ra);
      chk("rsp_valid", rsp_valid, m_rv);
      for (int i = 0; i < N; i++)
        chk($sformatf("rsp_data%0d", i), rsp_data[i*DW +: DW], m_data[i]);
    end
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_g = 0; m_ra = '0; m_rv = '0;
      for (int i = 0; i < N; i++) begin m_data[i] = '0; waits[i] = 0; end
      armed = 1;
    end else begin
      m_rv = '0;
      for (int i = 0; i < N; i++) if (!req_valid[i]) waits[i] = 0;
      if (m_busy) begin
        m_data[m_g] = regfile[m_ra];
        m_rv[m_g]   = 1'b1;
        rsp_count[m_g]++;
        m_busy = 0;
      end else if (g >= 0) begin
        chk("wait_bound", 64'(waits[g] <= N - 1), 64'd1);
        for (int i = 0; i < N; i++)
          if (i == g) waits[i] = 0;
          else if (req_valid[i]) waits[i]++;
        m_ra   = req_addr[g*AW +: AW];
        m_g    = g;
        m_ptr  = (g + 1) % N;
        m_busy = 1;
        grant_tot[g]++;
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    req_addr[ch*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int base, c0, c1;
    logic [N-1:0] acc;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[5] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin grant_tot[i] = 0; rsp_count[i] = 0; end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // ch0 reads address 5
    req_valid = 3'b001; set_addr(0, 5);
    @(negedge clk); chk("t1_ready", req_ready, 3'b001);
    step(); req_valid = '0;
    @(negedge clk); chk("t1_rf_ra", rf_ra, 5);
    @(negedge clk); chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_rsp_data", rsp_data[DW-1:0], 32'hDEADBEEF);
    step(); do_reset();

    // all three channels continuously valid
    base = grant_log.size();
    set_addr(0, 1); set_addr(1, 2); set_addr(2, 3);
    req_valid = 3'b111;
    repeat (7) step();
    req_valid = '0;
    repeat (3) step();
    chk("t2_ngrants", grant_log.size() - base, 4);
    chk("t2_g0", grant_log[base], 0);
    chk("t2_g1", grant_log[base+1], 1);
    chk("t2_g2", grant_log[base+2], 2);
    chk("t2_g3", grant_log[base+3], 0);
    for (int i = 1; i < 4; i++)
      chk("t2_spacing", grant_cyc[base+i] - grant_cyc[base+i-1], 2);
    chk("t2_data0", rsp_data[0*DW +: DW], regfile[1]);
    chk("t2_data1", rsp_data[1*DW +: DW], regfile[2]);
    chk("t2_data2", rsp_data[2*DW +: DW], regfile[3]);

    // wrap: after granting ch1 the pointer is 2; only ch0 asks
    do_reset();
    req_valid = 3'b010; set_addr(1, 10);
    @(negedge clk); chk("t3_first", req_ready, 3'b010);
    step(); req_valid = '0;
    step(); req_valid = 3'b001; set_addr(0, 11);
    @(negedge clk); chk("t3_wrap", req_ready, 3'b001);
    step(); req_valid = '0;
    step(); req_valid = 3'b111;
    @(negedge clk); chk("t3_ptr1", req_ready, 3'b010);
    step(); req_valid = '0;
    repeat (2) step();

    // reset while READ aborts ch1's read of address 7
    do_reset();
    req_valid = 3'b010; set_addr(1, 7);
    @(negedge clk); chk("t4_ready", req_ready, 3'b010);
    step(); req_valid = '0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t4_rsp_valid", rsp_valid, 3'b000);
    chk("t4_rf_ra", rf_ra, 0);
    chk("t4_data1", rsp_data[1*DW +: DW], 0);
    chk("t4_ready0", req_ready, 3'b000);
    step();

    // ch1 withdraws while ch0 is being served
    do_reset();
    c1 = grant_tot[1];
    req_valid = 3'b011; set_addr(0, 3); set_addr(1, 4);
    @(negedge clk); chk("t5_ready", req_ready, 3'b001);
    step(); req_valid = '0;
    step();
    @(negedge clk); chk("t5_idle_ready", req_ready, 3'b000);
    step();
    chk("t5_ch1_grants", grant_tot[1] - c1, 0);

    // back-to-back ch0 reads of 4 then 9
    do_reset();
    c0 = rsp_count[0];
    req_valid = 3'b001; set_addr(0, 4);
    step(); set_addr(0, 9);
    step();
    @(negedge clk);
    chk("t6_rv_a", rsp_valid, 3'b001);
    chk("t6_data_a", rsp_data[DW-1:0], regfile[4]);
    chk("t6_accept2", req_ready, 3'b001);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t6_rv_gap", rsp_valid, 3'b000);
    chk("t6_data_hold", rsp_data[DW-1:0], regfile[4]);
    step();
    @(negedge clk);
    chk("t6_rv_b", rsp_valid, 3'b001);
    chk("t6_data_b", rsp_data[DW-1:0], regfile[9]);
    repeat (2) step();
    chk("t6_pulses", rsp_count[0] - c0, 2);

    // randomized traffic with withdrawals and occasional reset
    do_reset();
    repeat (600) begin
      @(negedge clk); acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 63) == 0) rst = 1'b1;
      for (int c = 0; c < N; c++) begin
        if (req_valid[c] && !acc[c]) begin
          if ($urandom_range(0, 15) == 0) req_valid[c] = 1'b0;
        end else begin
          req_valid[c] = 1'($urandom_range(0, 1));
          set_addr(c, AW'($urandom));
        end
      end
    end
    req_valid = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
